// File: rtl/simplerisc_pkg.sv
// rtl/simplerisc_pkg.sv - shared widths, opcodes and fetch-state encoding for the SimpleRisc core
package simplerisc_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int INSTR_W_DEF = 32;
    localparam int OPCODE_W    = 5;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_MOD  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_CMP  = 5'd5;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd6;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd7;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'd8;
    localparam logic [OPCODE_W-1:0] OP_MOV  = 5'd9;
    localparam logic [OPCODE_W-1:0] OP_LSL  = 5'd10;
    localparam logic [OPCODE_W-1:0] OP_LSR  = 5'd11;
    localparam logic [OPCODE_W-1:0] OP_ASR  = 5'd12;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'd15;
    localparam logic [OPCODE_W-1:0] OP_BEQ  = 5'd16;
    localparam logic [OPCODE_W-1:0] OP_BGT  = 5'd17;
    localparam logic [OPCODE_W-1:0] OP_B    = 5'd18;
    localparam logic [OPCODE_W-1:0] OP_CALL = 5'd19;
    localparam logic [OPCODE_W-1:0] OP_RET  = 5'd20;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE    = 2'd0;
    localparam fetch_state_t BUSY    = 2'd1;
    localparam fetch_state_t DISCARD = 2'd2;

    typedef struct packed {
        logic [PC_W_DEF-1:0]    pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_pair_t;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W_DEF-1:0] instr);
        return instr[INSTR_W_DEF-1 -: OPCODE_W];
    endfunction

    // Instructions that EX may turn into a redirect of the fetch stream.
    function automatic logic is_flow_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_BEQ) || (op == OP_BGT) || (op == OP_B) ||
               (op == OP_CALL) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/simplerisc_fetch_fifo.sv
// rtl/simplerisc_fetch_fifo.sv - prefetch FIFO of {pc, instr} pairs with priority clear
module simplerisc_fetch_fifo #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [PC_W-1:0]            push_pc_i,
    input  logic [INSTR_W-1:0]         push_instr_i,
    input  logic                       pop_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic [PC_W-1:0]            head_pc_o,
    output logic [INSTR_W-1:0]         head_instr_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          empty, full, do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & ~full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) begin
            pc_mem[wr_ptr_q]    <= push_pc_i;
            instr_mem[wr_ptr_q] <= push_instr_i;
        end
    end

    assign count_o      = count_q;
    assign empty_o      = empty;
    assign head_pc_o    = empty ? '0 : pc_mem[rd_ptr_q];
    assign head_instr_o = empty ? '0 : instr_mem[rd_ptr_q];

endmodule

// File: rtl/simplerisc_fetch_unit.sv
// rtl/simplerisc_fetch_unit.sv - SimpleRisc instruction fetch front-end with prefetch FIFO and redirect
module simplerisc_fetch_unit
    import simplerisc_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk1,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               of_valid,
    input  logic               of_ready,
    output logic [PC_W-1:0]    of_pc,
    output logic [INSTR_W-1:0] of_instr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    fetch_state_t    state_q, state_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;

    logic            ack_v, can_issue, push, pop, empty;
    logic [CW-1:0]   count;

    // An ack is only meaningful against a request we are actually holding.
    assign ack_v     = imem_ack & req_q;
    assign can_issue = ~redirect_valid & (count < DEPTH_CNT);

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (ack_v) begin
                    state_d = IDLE;
                end else if (redirect_valid) begin
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (ack_v) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        push       = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    req_d  = 1'b1;
                    addr_d = fetch_pc_q;
                end
            end
            BUSY: begin
                if (ack_v) begin
                    req_d = 1'b0;
                    if (!redirect_valid) begin
                        push       = 1'b1;
                        fetch_pc_d = addr_q + 1'b1;
                    end
                end
            end
            DISCARD: begin
                if (ack_v) begin
                    req_d = 1'b0;
                end
            end
            default: req_d = 1'b0;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Masking with redirect keeps OF from consuming an entry that is being flushed.
    assign of_valid = ~empty & ~redirect_valid;
    assign pop      = of_valid & of_ready;

    simplerisc_fetch_fifo #(
        .DEPTH   (DEPTH),
        .PC_W    (PC_W),
        .INSTR_W (INSTR_W)
    ) u_fifo (
        .clk_i        (clk1),
        .rst_ni       (rst_n),
        .clear_i      (redirect_valid),
        .push_i       (push),
        .push_pc_i    (addr_q),
        .push_instr_i (imem_rdata),
        .pop_i        (pop),
        .count_o      (count),
        .empty_o      (empty),
        .head_pc_o    (of_pc),
        .head_instr_o (of_instr)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;

endmodule

// File: tb/tb_simplerisc_fetch_unit.sv
// tb/tb_simplerisc_fetch_unit.sv - randomized self-checking bench for simplerisc_fetch_unit
module tb_simplerisc_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        of_valid;
    logic        of_ready;
    logic [31:0] of_pc;
    logic [31:0] of_instr;

    always #5 clk1 = ~clk1;

    simplerisc_fetch_unit #(
        .PC_W     (32),
        .INSTR_W  (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk1           (clk1),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .of_valid       (of_valid),
        .of_ready       (of_ready),
        .of_pc          (of_pc),
        .of_instr       (of_instr)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_fetch, key, held_addr, rise_addr, on_ack_pc, force_pc, first_of_pc;
    bit          prev_req, stale, rise_seen, force_redir, redir_on_ack, capture_of, of_captured;
    int          lat, wait_cnt, lat_min, lat_max, ready_prob, redir_prob;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        model_fetch = 32'h0;
        prev_req    = 1'b0;
        stale       = 1'b0;
        wait_cnt    = 0;
    endtask

    // One clock: drive inputs after the edge, then compare and advance the reference model.
    task automatic cycle();
        logic        ack, redir, rdy, exp_v;
        logic [31:0] rpc;
        entry_t      e;
        @(posedge clk1);
        #1;
        rise_seen = 1'b0;
        ack = 1'b0;
        if (imem_req) begin
            if (!prev_req) begin
                lat      = int'($urandom_range(lat_max, lat_min));
                wait_cnt = 0;
            end
            ack = (wait_cnt == lat);
            wait_cnt++;
        end
        rpc = 32'h0;
        if (force_redir) begin
            redir       = 1'b1;
            rpc         = force_pc;
            force_redir = 1'b0;
        end else if (redir_on_ack && ack) begin
            redir        = 1'b1;
            rpc          = on_ack_pc;
            redir_on_ack = 1'b0;
        end else begin
            redir = ($urandom_range(99, 0) < redir_prob);
            case ($urandom_range(2, 0))
                0:       rpc = $urandom;
                1:       rpc = 32'hFFFF_FFFD + $urandom_range(2, 0);
                default: rpc = $urandom_range(255, 0);
            endcase
        end
        rdy = ($urandom_range(99, 0) < ready_prob);

        imem_ack       = ack;
        imem_rdata     = ack ? (imem_addr ^ key) : 32'h0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        of_ready       = rdy;
        #1;

        exp_v = (q.size() != 0) && !redir;
        check("of_valid", {31'b0, of_valid}, {31'b0, exp_v});
        if (q.size() != 0) begin
            check("of_pc", of_pc, q[0].pc);
            check("of_instr", of_instr, q[0].instr);
        end else begin
            check("of_pc_empty", of_pc, 32'h0);
        end
        if (imem_req && !prev_req) begin
            rise_seen = 1'b1;
            rise_addr = imem_addr;
            held_addr = imem_addr;
            stale     = 1'b0;
            check("req_addr", imem_addr, model_fetch);
            check("req_room", {31'b0, q.size() < DEPTH}, 32'h1);
        end else if (imem_req) begin
            check("addr_stable", imem_addr, held_addr);
        end

        if (exp_v && rdy && capture_of) begin
            first_of_pc = q[0].pc;
            of_captured = 1'b1;
            capture_of  = 1'b0;
        end
        if (redir) begin
            q.delete();
            model_fetch = rpc;
            if (imem_req && !ack) stale = 1'b1;
        end else begin
            if (exp_v && rdy) void'(q.pop_front());
            if (imem_req && ack && !stale) begin
                e.pc    = imem_addr;
                e.instr = imem_addr ^ key;
                q.push_back(e);
                model_fetch = model_fetch + 32'h1;
            end
        end
        prev_req = imem_req;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_rise(input string tag);
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (rise_seen) return;
        end
        check(tag, 32'h0, 32'h1);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        force_redir = 1'b1;
        force_pc    = pc;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; of_ready = 1'b0;
        force_redir = 1'b0; redir_on_ack = 1'b0; capture_of = 1'b0; of_captured = 1'b0;
        key = 32'h0; lat_min = 0; lat_max = 0; ready_prob = 100; redir_prob = 0;
        lat = 0; rise_addr = 32'h0; held_addr = 32'h0; first_of_pc = 32'h0;
        on_ack_pc = 32'h0; force_pc = 32'h0;
        model_reset();
        repeat (3) @(posedge clk1);
        #1;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_of_valid", {31'b0, of_valid}, 32'h0);
        check("rst_of_pc", of_pc, 32'h0);
        check("rst_of_instr", of_instr, 32'h0);
        rst_n = 1'b1;

        // Zero-wait memory, instr == addr, OF always ready.
        run(30);

        // Back-pressure fills the FIFO and stops fetching.
        redirect_to(32'h0);
        ready_prob = 0;
        run(20);
        check("full_req_low", {31'b0, imem_req}, 32'h0);
        check("full_of_valid", {31'b0, of_valid}, 32'h1);
        check("full_head", of_pc, 32'h0);
        ready_prob = 100;
        wait_rise("resume_timeout");
        check("resume_addr", rise_addr, 32'h4);
        run(10);

        // Redirect while a slow request is outstanding.
        lat_min = 3; lat_max = 3; key = 32'h5A5A_0000;
        redirect_to(32'h0);
        for (int i = 0; i < 100 && !(rise_seen && rise_addr == 32'h5); i++) cycle();
        check("addr5_seen", rise_addr, 32'h5);
        force_redir = 1'b1; force_pc = 32'h40; capture_of = 1'b1; of_captured = 1'b0;
        cycle();
        wait_rise("redir40_timeout");
        check("redir40_addr", rise_addr, 32'h40);
        run(20);
        check("first_of_after_redir", first_of_pc, 32'h40);
        check("first_of_captured", {31'b0, of_captured}, 32'h1);
        capture_of = 1'b0;

        // Redirect coinciding with an ack while two entries are buffered.
        lat_min = 2; lat_max = 2; ready_prob = 0;
        redirect_to(32'h0);
        for (int i = 0; i < 100 && q.size() < 2; i++) cycle();
        redir_on_ack = 1'b1; on_ack_pc = 32'h100;
        for (int i = 0; i < 100 && redir_on_ack; i++) cycle();
        check("ack_redir_fired", {31'b0, redir_on_ack}, 32'h0);
        cycle();
        check("ack_redir_empty", {31'b0, of_valid}, 32'h0);
        ready_prob = 100;
        if (!rise_seen) wait_rise("redir100_timeout");
        check("redir100_addr", rise_addr, 32'h100);
        run(10);

        // Random mix of latency, back-pressure and redirects.
        lat_min = 0; lat_max = 2; ready_prob = 60; redir_prob = 4; key = $urandom;
        run(400);
        redir_prob = 0;

        // Address wrap at the top of the PC space.
        lat_min = 0; lat_max = 1; ready_prob = 100;
        redirect_to(32'hFFFF_FFFF);
        wait_rise("wrap_hi_timeout");
        check("wrap_hi_addr", rise_addr, 32'hFFFF_FFFF);
        wait_rise("wrap_lo_timeout");
        check("wrap_lo_addr", rise_addr, 32'h0);
        run(10);

        // Reset in the middle of an outstanding request.
        lat_min = 3; lat_max = 3;
        wait_rise("pre_reset_timeout");
        @(posedge clk1);
        #1;
        rst_n = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; of_ready = 1'b0;
        #1;
        check("rst_mid_req", {31'b0, imem_req}, 32'h0);
        check("rst_mid_of_valid", {31'b0, of_valid}, 32'h0);
        check("rst_mid_of_pc", of_pc, 32'h0);
        imem_ack = 1'b1;
        @(posedge clk1);
        #1;
        check("rst_stray_ack_req", {31'b0, imem_req}, 32'h0);
        imem_ack = 1'b0;
        model_reset();
        rst_n = 1'b1;
        wait_rise("post_reset_timeout");
        check("post_reset_addr", rise_addr, 32'h0);
        run(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
